store_buffer: RTL

- Parametrised, buffered successor to the single-request CPU store path.
- Accepts byte-masked stores at any byte address into a DEPTH-entry FIFO, so the core does not stall on one outstanding store.
- Drains the FIFO to the memory port in order, one or two aligned beats per store; beats whose byte mask is all zero are skipped.
- Reports idle/occupancy so the core can fence loads behind pending stores.

---
 rtl/store_buffer_if.sv | 41 ++++
 rtl/store_buffer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: core-side store handshake, memory beat port and status.
// The store buffer uses the slave modport; the core/memory side uses master.
interface store_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic                  write_ready;
    logic                  write_req;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [BYTES-1:0]      write_byte_enable;

    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [BYTES-1:0]      mem_byte_enable;
    logic                  mem_write_req;

    logic                  idle;
    logic [CW-1:0]         pending_count;

    modport slave (
        output write_ready,
        input  write_req, write_addr, write_data, write_byte_enable,
        input  mem_ready,
        output mem_addr, mem_write_data, mem_byte_enable, mem_write_req,
        output idle, pending_count
    );

    modport master (
        input  write_ready,
        output write_req, write_addr, write_data, write_byte_enable,
        output mem_ready,
        input  mem_addr, mem_write_data, mem_byte_enable, mem_write_req,
        input  idle, pending_count
    );
endinterface

// File: rtl/store_buffer.sv
// Buffered store path: DEPTH-entry FIFO of byte-masked stores drained in order
// to an aligned memory port as one or two beats per store.
module store_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input logic          clk,
    input logic          reset,
    store_buffer_if.slave bus
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);
    localparam int unsigned PTRW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ISSUE_IDLE,
        ISSUE_LOW,
        ISSUE_HIGH
    } issue_state_e;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [BYTES-1:0]      fifo_be_q   [DEPTH];
    logic [PTRW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PTRW:0]         count_q, count_d;

    issue_state_e          state_q;
    logic [ADDR_WIDTH-1:0] hi_addr_q;
    logic [DATA_WIDTH-1:0] hi_data_q;
    logic [BYTES-1:0]      hi_be_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [BYTES-1:0]      mem_be_q;
    logic                  mem_req_q;

    logic                  push, pop, beat_done, last_beat;
    logic [ADDR_WIDTH-1:0] head_addr, low_addr, high_addr;
    logic [OFFS-1:0]       head_off;
    logic [2*DATA_WIDTH-1:0] wide;
    logic [2*BYTES-1:0]      wmask;

    // Ready depends only on registered occupancy; a same-cycle pop does not free a slot.
    assign bus.write_ready = (count_q < (PTRW+1)'(DEPTH));
    assign push      = bus.write_req && bus.write_ready;
    assign beat_done = mem_req_q && bus.mem_ready;
    assign last_beat = (state_q == ISSUE_HIGH) || (state_q == ISSUE_LOW && hi_be_q == '0);
    assign pop       = (count_q != '0) &&
                       ((state_q == ISSUE_IDLE) || (beat_done && last_beat));

    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_off  = head_addr[OFFS-1:0];
    assign wide      = {{DATA_WIDTH{1'b0}}, fifo_data_q[rd_ptr_q]} << {head_off, 3'b000};
    assign wmask     = {{BYTES{1'b0}}, fifo_be_q[rd_ptr_q]} << head_off;
    assign low_addr  = {head_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
    assign high_addr = low_addr + ADDR_WIDTH'(BYTES);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.write_addr;
            fifo_data_q[wr_ptr_q] <= bus.write_data;
            fifo_be_q[wr_ptr_q]   <= bus.write_byte_enable;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ISSUE_IDLE;
            hi_addr_q  <= '0;
            hi_data_q  <= '0;
            hi_be_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_be_q   <= '0;
            mem_req_q  <= 1'b0;
        end else if (pop) begin
            hi_addr_q <= high_addr;
            hi_data_q <= wide[2*DATA_WIDTH-1:DATA_WIDTH];
            hi_be_q   <= wmask[2*BYTES-1:BYTES];
            if (wmask[BYTES-1:0] != '0) begin
                state_q    <= ISSUE_LOW;
                mem_addr_q <= low_addr;
                mem_data_q <= wide[DATA_WIDTH-1:0];
                mem_be_q   <= wmask[BYTES-1:0];
                mem_req_q  <= 1'b1;
            end else if (wmask[2*BYTES-1:BYTES] != '0) begin
                state_q    <= ISSUE_HIGH;
                mem_addr_q <= high_addr;
                mem_data_q <= wide[2*DATA_WIDTH-1:DATA_WIDTH];
                mem_be_q   <= wmask[2*BYTES-1:BYTES];
                mem_req_q  <= 1'b1;
            end else begin
                // Empty-mask store: dropped, next entry is taken from ISSUE_IDLE.
                state_q   <= ISSUE_IDLE;
                mem_req_q <= 1'b0;
            end
        end else if (beat_done) begin
            if (state_q == ISSUE_LOW && hi_be_q != '0) begin
                state_q    <= ISSUE_HIGH;
                mem_addr_q <= hi_addr_q;
                mem_data_q <= hi_data_q;
                mem_be_q   <= hi_be_q;
            end else begin
                state_q   <= ISSUE_IDLE;
                mem_req_q <= 1'b0;
            end
        end
    end

    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_write_data  = mem_data_q;
    assign bus.mem_byte_enable = mem_be_q;
    assign bus.mem_write_req   = mem_req_q;
    assign bus.idle            = (count_q == '0) && (state_q == ISSUE_IDLE);
    assign bus.pending_count   = count_q + (PTRW+1)'(state_q != ISSUE_IDLE);
endmodule
